// File: rtl/rom_pair_sequencer_if.sv
// ----------------------------------------------------------------------------
// rom_pair_sequencer_if
// Bundles the host run-request signals, the ROM/ALU datapath address/result
// signals and the result-RAM write port of rom_pair_sequencer.
//
// Handshake: a run request is a level on `start` that is accepted on a rising
// clock edge only while `busy` is 0. The acceptance edge is the point where
// base_addr1/base_addr2/num_pairs are captured. `busy` is 1 from that edge
// until the edge that raises the one-cycle `done` pulse, so `start` can be
// held or pulsed freely while a run is in progress without effect.
//
// Modports:
//   master : the sequencer (drives addresses, RAM port, status)
//   slave  : the environment (host + datapath + RAM)
// ----------------------------------------------------------------------------
interface rom_pair_sequencer_if;
  // host side
  logic        start;
  logic [2:0]  base_addr1;
  logic [2:0]  base_addr2;
  logic [3:0]  num_pairs;
  logic        busy;
  logic        done;
  // datapath side
  logic [7:0]  result;
  logic [2:0]  rom_addr1;
  logic [2:0]  rom_addr2;
  // result RAM write port and running sum
  logic        ram_we;
  logic [2:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic [10:0] acc;

  modport master (
    input  start, base_addr1, base_addr2, num_pairs, result,
    output busy, done, rom_addr1, rom_addr2, ram_we, ram_addr, ram_wdata, acc
  );

  modport slave (
    output start, base_addr1, base_addr2, num_pairs, result,
    input  busy, done, rom_addr1, rom_addr2, ram_we, ram_addr, ram_wdata, acc
  );
endinterface

// File: rtl/rom_pair_sequencer.sv
// ----------------------------------------------------------------------------
// rom_pair_sequencer
// Walks the ROM/ALU datapath through up to 8 address pairs per run. Each pair
// is launched on the address outputs, held for LAT cycles, then the datapath
// result is written to the result RAM (address = pair index) and added to an
// 11-bit running sum.
//
// Ports:
//   clk      : system clock, rising edge
//   reset    : synchronous active-high reset
//   bus      : rom_pair_sequencer_if.master (host, datapath and RAM signals)
//   state_o  : current FSM state (0 IDLE, 1 WAIT, 2 WRITE) for observation
//
// Parameter:
//   LAT : datapath latency in cycles, 1..7
// ----------------------------------------------------------------------------
module rom_pair_sequencer #(
  parameter int unsigned LAT = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  rom_pair_sequencer_if.master        bus,
  output logic [1:0]                  state_o
);

  localparam logic [2:0] LAT_C = 3'(LAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  n_q, n_d;
  logic [2:0]  base1_q, base1_d;
  logic [2:0]  base2_q, base2_d;
  logic [2:0]  k_q, k_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  a1_q, a1_d;
  logic [2:0]  a2_q, a2_d;
  logic [2:0]  waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [10:0] acc_q, acc_d;
  logic        we_q, we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  // An empty run still has to report `done` one cycle after acceptance;
  // this flag carries that pending pulse while the FSM stays in IDLE.
  logic        empty_q, empty_d;
  logic [3:0]  n_eff;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    base1_d = base1_q;
    base2_d = base2_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    acc_d   = acc_q;
    we_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    empty_d = empty_q;
    n_eff   = (bus.num_pairs > 4'd8) ? 4'd8 : bus.num_pairs;

    case (state_q)
      S_IDLE: begin
        if (empty_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          empty_d = 1'b0;
        end else if (bus.start) begin
          n_d     = n_eff;
          base1_d = bus.base_addr1;
          base2_d = bus.base_addr2;
          acc_d   = 11'd0;
          k_d     = 3'd0;
          busy_d  = 1'b1;
          if (n_eff == 4'd0) begin
            empty_d = 1'b1;
          end else begin
            a1_d    = bus.base_addr1;
            a2_d    = bus.base_addr2;
            cnt_d   = LAT_C;
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        // cnt_q == 1 marks the edge LAT cycles after the address launch
        if (cnt_q == 3'd1) begin
          wdata_d = bus.result;
          waddr_d = k_q;
          we_d    = 1'b1;
          acc_d   = acc_q + 11'(bus.result);
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      S_WRITE: begin
        if ({1'b0, k_q} == n_q - 4'd1) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          // 3-bit sums wrap naturally, independently per address
          k_d     = k_q + 3'd1;
          a1_d    = base1_q + k_q + 3'd1;
          a2_d    = base2_q + k_q + 3'd1;
          cnt_d   = LAT_C;
          state_d = S_WAIT;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      n_q     <= 4'd0;
      base1_q <= 3'd0;
      base2_q <= 3'd0;
      k_q     <= 3'd0;
      cnt_q   <= 3'd0;
      a1_q    <= 3'd0;
      a2_q    <= 3'd0;
      waddr_q <= 3'd0;
      wdata_q <= 8'd0;
      acc_q   <= 11'd0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      base1_q <= base1_d;
      base2_q <= base2_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      acc_q   <= acc_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      empty_q <= empty_d;
    end
  end

  assign bus.rom_addr1 = a1_q;
  assign bus.rom_addr2 = a2_q;
  assign bus.ram_we    = we_q;
  assign bus.ram_addr  = waddr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.acc       = acc_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign state_o       = state_q;

endmodule

// File: doc/rom_pair_sequencer.md
# rom_pair_sequencer

Controller that sequences the two-address ROM/ALU datapath (3-bit `rom_addr1`/`rom_addr2` in, 8-bit `result` out) through a run of up to 8 address pairs without host involvement. On `start` it launches each address pair, waits the datapath latency, writes each result into an 8-entry result RAM and keeps a running sum. It sits between the host/test sequencer and the datapath and owns the datapath address inputs for the whole run.

## Interface
- `LAT`, default 2: datapath latency in cycles from an address change to a valid `result`; legal range 1..7.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE.
- `base_addr1`  in  3  first `rom_addr1` of the run; captured on accepted `start`.
- `base_addr2`  in  3  first `rom_addr2` of the run; captured on accepted `start`.
- `num_pairs`  in  4  pair count; 0 = empty run; values above 8 clamp to 8; captured on accepted `start`.
- `result`  in  8  datapath output.
- `rom_addr1`  out  3  datapath address 1, registered.
- `rom_addr2`  out  3  datapath address 2, registered.
- `ram_we`  out  1  result RAM write strobe, one cycle per pair.
- `ram_addr`  out  3  result RAM write address, equal to the pair index k.
- `ram_wdata`  out  8  result RAM write data.
- `acc`  out  11  running unsigned sum of this run's results.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at the end of a run.

## Operation
- States: IDLE, WAIT, WRITE.
- IDLE with `start`=1:
  - captures n = min(`num_pairs`, 8), `base_addr1` and `base_addr2`;
  - clears `acc` and sets k=0;
  - drives `rom_addr1`=base1 and `rom_addr2`=base2;
  - loads the wait counter with LAT and enters WAIT;
  - with n=0 it instead stays in IDLE and pulses `done` the next cycle, issuing no writes.
- WAIT: holds the addresses and decrements the counter. On the edge where LAT cycles have elapsed since the address launch it:
  - samples `result` into `ram_wdata`;
  - sets `ram_addr`=k and `ram_we`=1;
  - adds `result` to `acc`;
  - enters WRITE.
- WRITE (one cycle, `ram_we` high):
  - if k=n-1: goes to IDLE and asserts `done` at the next edge;
  - otherwise: k+1, launches `rom_addr1`=(base1+k+1) mod 8 and `rom_addr2`=(base2+k+1) mod 8, reloads the counter and returns to WAIT.
- Address arithmetic is 3-bit with natural wrap (7+1 → 0), independently per address.
- `acc` is an 11-bit unsigned sum; at most 8×255 = 2040, so it never overflows.
- `start` is ignored while `busy`=1.
- `rom_addr1`/`rom_addr2`, `ram_addr`, `ram_wdata` and `acc` hold their last values after a run.
- `reset` mid-run aborts immediately:
  - next state is IDLE;
  - no further writes and no `done` pulse;
  - every output returns to its reset value.
- Reset values: all outputs 0; state IDLE.

## Timing
- Accepted `start` sampled at edge S: pair k addresses appear at edge S+k(LAT+1).
- `result` for pair k is sampled at edge S+k(LAT+1)+LAT.
- `ram_we` is high for exactly the one cycle following that edge.
- Per-pair period: LAT+1 cycles; there is no overlap between pairs.
- `done` rises at edge S+n(LAT+1), high for one cycle. Empty run: `done` at S+1.
- `busy` rises at edge S and falls at the same edge `done` rises.
- The state is IDLE during the `done` cycle, so a `start` in that cycle is accepted (back-to-back runs).
- The datapath's `result` must be stable for the whole sampling cycle; the block applies no extra registering on input.

## Test plan
- Bench datapath model: `result` = 8·a1 + a2, delayed LAT cycles; LAT=2 throughout.
- Basic run: base1=0, base2=1, n=3 after reset. Required response:
  - addresses (0,1), (1,2), (2,3) at S, S+3 and S+6;
  - writes RAM[0]=1, RAM[1]=10, RAM[2]=19;
  - `acc`=30;
  - `done` pulse at S+9 and `busy` low from S+9.
- Wrap-around: base1=7, base2=6, n=2. Required response:
  - addresses (7,6) then (0,7);
  - writes RAM[0]=62, RAM[1]=7;
  - `acc`=69.
- Count edges: n=0 → `done` at S+1, `ram_we` never high. n=12 → clamps to 8, eight writes to `ram_addr` 0..7, `done` at S+24.
- Handshake:
  - `start` pulsed at S+4 during a run is ignored, leaving the sequence and values unchanged;
  - `start` in the `done` cycle launches a new run at the next edge, with `acc` restarting from 0.
- Reset mid-run: base1=0, base2=1, n=3, `reset` high for one cycle at S+4. Required response:
  - only RAM[0]=1 is written;
  - no `done` pulse;
  - all outputs read 0 after the reset edge;
  - a following start with n=1 completes normally (`done` at S'+3).
